leaf_port_bridge: RTL and testbench
===================================

// Module: leaf_port_bridge
// PURPOSE
//  Parametrised per-port elastic buffer between leaf_interface and the user kernel in a leaf shell.
//  Generalises the fixed i4o4 shell wiring to any number of input and output ports.
//  Inserts one FIFO per port in each direction. Freezes egress toward the BFT while resend is high.
//  Reports per-direction activity for shell-level drain/idle detection.
// PARAMETERS
//  PAYLOAD_BITS   32  data width of every port
//  NUM_IN_PORTS   4   interface->user ports, 1..15
//  NUM_OUT_PORTS  4   user->interface ports, 1..15
//  FIFO_DEPTH     4   entries per port FIFO, power of 2, >=2
// PORTS
//  clk                      in   1                       leaf clock (same domain as leaf_interface)
//  reset                    in   1                       synchronous, active-high
//  resend                   in   1                       BFT resend in progress; freezes egress
//  dout_leaf_interface2user in   NUM_IN_PORTS*PAYLOAD_BITS  data from interface, port p at [p*PB +: PB]
//  vld_interface2user       in   NUM_IN_PORTS            valid from interface
//  ack_user2interface       out  NUM_IN_PORTS            ready to interface
//  dout_bridge2user         out  NUM_IN_PORTS*PAYLOAD_BITS  data to kernel
//  vld_bridge2user          out  NUM_IN_PORTS            valid to kernel
//  ack_user2bridge          in   NUM_IN_PORTS            ready from kernel
//  din_user2bridge          in   NUM_OUT_PORTS*PAYLOAD_BITS data from kernel
//  vld_user2bridge          in   NUM_OUT_PORTS           valid from kernel
//  ack_bridge2user          out  NUM_OUT_PORTS           ready to kernel
//  din_leaf_user2interface  out  NUM_OUT_PORTS*PAYLOAD_BITS data to interface
//  vld_user2interface       out  NUM_OUT_PORTS           valid to interface
//  ack_interface2user       in   NUM_OUT_PORTS           ready from interface
//  in_busy / out_busy       out  1                       OR of non-empty over ingress / egress FIFOs
// BEHAVIOUR
//  - One clock domain. Reset is synchronous, active-high.
//  - Handshake on every link: a transfer occurs in a cycle with vld & ack both high.
//    A valid, once raised, holds its data stable until it is accepted.
//  - Reset:
//    - All FIFOs empty; all vld_* outputs and busy flags go to 0.
//    - Every ack_* output goes to 1 in the first cycle after reset deasserts.
//    - Data outputs are don't-care while the matching vld is 0.
//  - Per FIFO:
//    - Push side: ack = !full. Push = vld_in & ack.
//    - Pop side: vld_out = !empty. Pop = vld_out & ack_in.
//    - Occupancy counter is $clog2(FIFO_DEPTH)+1 bits. Read/write pointers wrap modulo FIFO_DEPTH.
//  - Latency: a word pushed in cycle N is visible at the output in N+1 (no combinational path from
//    input to output). Throughput is 1 word/cycle/port.
//  - Simultaneous push and pop:
//    - Non-empty, not full: count unchanged.
//    - Full: push is blocked because ack=0; the pop proceeds and ack rises next cycle.
//    - Empty: the output is not valid, so only the push happens.
//  - resend=1:
//    - vld_user2interface is forced to 0 on all output ports and no egress pop occurs.
//    - Egress FIFO contents are kept.
//    - Egress FIFOs still accept kernel data until full.
//    - Ingress is unaffected.
//    - Output resumes from the same head word in the cycle resend falls.
//  - Reset mid-operation discards all buffered words. No partial-word state exists.
//  - Ports are fully independent; a stall on one port never blocks another.
// STRUCTURE
//  - Package leaf_shell_pkg:
//    - PACKET_BITS=49, PAYLOAD_BITS=32, NUM_PORT_BITS=4 constants.
//    - function port_slice index helper.
//  - Sub-module leaf_port_fifo (PAYLOAD_BITS, FIFO_DEPTH) with registered head.
//    It is instantiated through two generate loops: NUM_IN_PORTS + NUM_OUT_PORTS copies.
//  - Top level holds only the resend gating and the busy OR-reduction.
// TESTING
//  1. Reset, then idle.
//     -> all ack=1, all vld=0, in_busy=out_busy=0.
//  2. Interface port 2 sends 0xA5A5_0001..0004 back-to-back while the kernel ack is held at 0
//     (FIFO_DEPTH=4).
//     -> ack_user2interface[2] falls after the 4th push.
//     -> Then raise the kernel ack: the words are delivered in order, 1/cycle, and ack rises again.
//  3. Kernel pushes 0x1..0x3 on output port 0; resend rises before the 2nd pop.
//     -> vld_user2interface=0 while resend is high.
//     -> 0x2, 0x3 follow after resend falls; no loss, no duplicate.
//  4. Full FIFO with simultaneous push attempt and pop.
//     -> count goes 4->3; the blocked word is accepted the next cycle.
//  5. Reset asserted with 3 words buffered on every port.
//     -> next cycle all vld=0, busy=0; post-reset traffic starts cleanly.
//  6. Random vld/ack on all ports, NUM_IN_PORTS=NUM_OUT_PORTS=7.
//     -> scoreboard shows per-port ordering with zero loss and no cross-port corruption.

Source files
------------

// File: rtl/leaf_port_bridge_pkg.sv
// Shared leaf-shell constants and the per-port bus slicing helper.
package leaf_shell_pkg;

  localparam int PACKET_BITS   = 49;
  localparam int PAYLOAD_BITS  = 32;
  localparam int NUM_PORT_BITS = 4;

  // LSB of port `port` inside a flattened multi-port data bus.
  function automatic int unsigned port_slice(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/leaf_port_bridge_if.sv
// Handshake bundle between leaf_interface, the bridge and the user kernel.
interface leaf_port_bridge_if
  import leaf_shell_pkg::*;
#(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 4,
  parameter int NUM_OUT_PORTS = 4
);

  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
  logic [NUM_IN_PORTS-1:0]               vld_interface2user;
  logic [NUM_IN_PORTS-1:0]               ack_user2interface;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_bridge2user;
  logic [NUM_IN_PORTS-1:0]               vld_bridge2user;
  logic [NUM_IN_PORTS-1:0]               ack_user2bridge;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user2bridge;
  logic [NUM_OUT_PORTS-1:0]              vld_user2bridge;
  logic [NUM_OUT_PORTS-1:0]              ack_bridge2user;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

  // Bridge side.
  modport slave (
    input  dout_leaf_interface2user, vld_interface2user, ack_user2bridge,
    input  din_user2bridge, vld_user2bridge, ack_interface2user,
    output ack_user2interface, dout_bridge2user, vld_bridge2user,
    output ack_bridge2user, din_leaf_user2interface, vld_user2interface
  );

  // Interface + kernel side.
  modport master (
    output dout_leaf_interface2user, vld_interface2user, ack_user2bridge,
    output din_user2bridge, vld_user2bridge, ack_interface2user,
    input  ack_user2interface, dout_bridge2user, vld_bridge2user,
    input  ack_bridge2user, din_leaf_user2interface, vld_user2interface
  );

endinterface

// File: rtl/leaf_port_bridge_fifo.sv
// Single-port elastic FIFO with valid/ack on both sides; head word read from registered storage.
module leaf_port_fifo #(
  parameter int PAYLOAD_BITS = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    din_vld,
  output logic                    din_ack,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    dout_vld,
  input  logic                    dout_ack
);
  import leaf_shell_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic                    push;
  logic                    pop;

  assign din_ack  = (count != CW'(FIFO_DEPTH));
  assign dout_vld = (count != '0);
  assign push     = din_vld & din_ack;
  assign pop      = dout_vld & dout_ack;
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/leaf_port_bridge.sv
// Per-port FIFO bridge between leaf_interface and the user kernel, with resend freeze on egress.
module leaf_port_bridge #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 4,
  parameter int NUM_OUT_PORTS = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             resend,
  leaf_port_bridge_if.slave bus,
  output logic             in_busy,
  output logic             out_busy
);
  import leaf_shell_pkg::*;

  logic [NUM_IN_PORTS-1:0]               in_ack;
  logic [NUM_IN_PORTS-1:0]               in_vld;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_data;
  logic [NUM_OUT_PORTS-1:0]              eg_ack;
  logic [NUM_OUT_PORTS-1:0]              eg_vld;
  logic [NUM_OUT_PORTS-1:0]              eg_pop_ack;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] eg_data;

  for (genvar p = 0; p < NUM_IN_PORTS; p++) begin : g_ingress
    leaf_port_fifo #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .din      (bus.dout_leaf_interface2user[port_slice(p, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .din_vld  (bus.vld_interface2user[p]),
      .din_ack  (in_ack[p]),
      .dout     (in_data[port_slice(p, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .dout_vld (in_vld[p]),
      .dout_ack (bus.ack_user2bridge[p])
    );
  end

  for (genvar p = 0; p < NUM_OUT_PORTS; p++) begin : g_egress
    leaf_port_fifo #(
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .din      (bus.din_user2bridge[port_slice(p, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .din_vld  (bus.vld_user2bridge[p]),
      .din_ack  (eg_ack[p]),
      .dout     (eg_data[port_slice(p, PAYLOAD_BITS) +: PAYLOAD_BITS]),
      .dout_vld (eg_vld[p]),
      .dout_ack (eg_pop_ack[p])
    );
  end

  assign bus.ack_user2interface = in_ack;
  assign bus.vld_bridge2user    = in_vld;
  assign bus.dout_bridge2user   = in_data;

  // Resend hides the head from the BFT and blocks the pop; the head word stays put.
  assign eg_pop_ack                  = bus.ack_interface2user & {NUM_OUT_PORTS{~resend}};
  assign bus.vld_user2interface      = eg_vld & {NUM_OUT_PORTS{~resend}};
  assign bus.ack_bridge2user         = eg_ack;
  assign bus.din_leaf_user2interface = eg_data;

  // Busy reflects buffered words, independent of the resend gating.
  assign in_busy  = |in_vld;
  assign out_busy = |eg_vld;

endmodule

// File: tb/tb_leaf_port_bridge.sv
// Scoreboard bench for leaf_port_bridge: per-port queue model, directed scenarios, then random traffic.
module tb_leaf_port_bridge;
  localparam int PB    = 32;
  localparam int NI    = 7;
  localparam int NO    = 7;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic resend;
  logic in_busy;
  logic out_busy;

  always #5 clk = ~clk;

  leaf_port_bridge_if #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO)) bus ();

  leaf_port_bridge #(
    .PAYLOAD_BITS  (PB),
    .NUM_IN_PORTS  (NI),
    .NUM_OUT_PORTS (NO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .resend   (resend),
    .bus      (bus),
    .in_busy  (in_busy),
    .out_busy (out_busy)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: one ordered queue of accepted words per port, capacity DEPTH.
  logic [PB-1:0] in_q  [NI][$];
  logic [PB-1:0] out_q [NO][$];
  logic [PB-1:0] eg0_log [$];
  bit            model_valid = 1'b0;
  bit            in_fire  [NI];
  bit            out_fire [NO];

  task automatic chk(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    bit any_in;
    bit any_out;
    if (model_valid) begin
      any_in  = 1'b0;
      any_out = 1'b0;
      for (int p = 0; p < NI; p++) begin
        bit ev;
        ev = (in_q[p].size() != 0);
        any_in |= ev;
        chk($sformatf("in%0d_ack", p), PB'(bus.ack_user2interface[p]), PB'(in_q[p].size() < DEPTH));
        chk($sformatf("in%0d_vld", p), PB'(bus.vld_bridge2user[p]), PB'(ev));
        if (ev && bus.vld_bridge2user[p])
          chk($sformatf("in%0d_data", p), bus.dout_bridge2user[p*PB +: PB], in_q[p][0]);
      end
      for (int p = 0; p < NO; p++) begin
        bit ev;
        ev = (out_q[p].size() != 0) && !resend;
        any_out |= (out_q[p].size() != 0);
        chk($sformatf("out%0d_ack", p), PB'(bus.ack_bridge2user[p]), PB'(out_q[p].size() < DEPTH));
        chk($sformatf("out%0d_vld", p), PB'(bus.vld_user2interface[p]), PB'(ev));
        if (ev && bus.vld_user2interface[p])
          chk($sformatf("out%0d_data", p), bus.din_leaf_user2interface[p*PB +: PB], out_q[p][0]);
      end
      chk("in_busy", PB'(in_busy), PB'(any_in));
      chk("out_busy", PB'(out_busy), PB'(any_out));
    end

    if (reset) begin
      for (int p = 0; p < NI; p++) begin in_q[p].delete();  in_fire[p]  = 1'b0; end
      for (int p = 0; p < NO; p++) begin out_q[p].delete(); out_fire[p] = 1'b0; end
      model_valid = 1'b1;
    end else if (model_valid) begin
      for (int p = 0; p < NI; p++) begin
        bit pop;
        in_fire[p] = bus.vld_interface2user[p] && (in_q[p].size() < DEPTH);
        pop        = (in_q[p].size() != 0) && bus.ack_user2bridge[p];
        if (pop) void'(in_q[p].pop_front());
        if (in_fire[p]) in_q[p].push_back(bus.dout_leaf_interface2user[p*PB +: PB]);
      end
      for (int p = 0; p < NO; p++) begin
        bit pop;
        out_fire[p] = bus.vld_user2bridge[p] && (out_q[p].size() < DEPTH);
        pop         = (out_q[p].size() != 0) && !resend && bus.ack_interface2user[p];
        if (pop) begin
          if (p == 0) eg0_log.push_back(out_q[p][0]);
          void'(out_q[p].pop_front());
        end
        if (out_fire[p]) out_q[p].push_back(bus.din_user2bridge[p*PB +: PB]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_in(input int p, input logic [PB-1:0] w, output int cyc);
    bus.vld_interface2user[p] = 1'b1;
    bus.dout_leaf_interface2user[p*PB +: PB] = w;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (in_fire[p]) begin
        bus.vld_interface2user[p] = 1'b0;
        cyc = i;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL in%0d_send_timeout actual=no_accept required=accept_within_50", p);
    bus.vld_interface2user[p] = 1'b0;
    cyc = 50;
  endtask

  task automatic send_out(input int p, input logic [PB-1:0] w);
    bus.vld_user2bridge[p] = 1'b1;
    bus.din_user2bridge[p*PB +: PB] = w;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (out_fire[p]) begin
        bus.vld_user2bridge[p] = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL out%0d_send_timeout actual=no_accept required=accept_within_50", p);
    bus.vld_user2bridge[p] = 1'b0;
  endtask

  initial begin
    int cyc;
    reset  = 1'b1;
    resend = 1'b0;
    bus.dout_leaf_interface2user = '0;
    bus.vld_interface2user       = '0;
    bus.ack_user2bridge          = '0;
    bus.din_user2bridge          = '0;
    bus.vld_user2bridge          = '0;
    bus.ack_interface2user       = '0;

    // Reset then idle.
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("idle_ack_in",  PB'(bus.ack_user2interface), PB'(7'h7F));
    chk("idle_ack_out", PB'(bus.ack_bridge2user),    PB'(7'h7F));
    chk("idle_vld_in",  PB'(bus.vld_bridge2user),    '0);
    chk("idle_vld_out", PB'(bus.vld_user2interface), '0);
    repeat (2) tick();

    // Port 2 fills while the kernel stalls, then drains in order.
    for (int unsigned i = 1; i <= 4; i++) send_in(2, 32'hA5A5_0000 + i, cyc);
    tick();
    chk("p2_full_ack", PB'(bus.ack_user2interface[2]), '0);
    bus.ack_user2bridge[2] = 1'b1;
    repeat (6) tick();
    chk("p2_ack_recovered", PB'(bus.ack_user2interface[2]), PB'(1'b1));
    bus.ack_user2bridge[2] = 1'b0;

    // Egress port 0 with resend raised between the first and second pop.
    eg0_log.delete();
    bus.ack_interface2user[0] = 1'b1;
    send_out(0, 32'h1);
    send_out(0, 32'h2);
    resend = 1'b1;
    send_out(0, 32'h3);
    repeat (3) tick();
    chk("resend_vld0", PB'(bus.vld_user2interface[0]), '0);
    resend = 1'b0;
    repeat (5) tick();
    chk("eg0_count", PB'(eg0_log.size()), PB'(3));
    for (int i = 0; i < 3; i++)
      chk($sformatf("eg0_word%0d", i), (eg0_log.size() > i) ? eg0_log[i] : 'x, PB'(i + 1));
    bus.ack_interface2user[0] = 1'b0;

    // Full FIFO: push attempt coincides with a pop; blocked word enters one cycle later.
    for (int unsigned i = 1; i <= 4; i++) send_in(1, 32'hB000_0000 + i, cyc);
    bus.ack_user2bridge[1] = 1'b1;
    send_in(1, 32'hB000_0005, cyc);
    chk("p1_blocked_latency", PB'(cyc), PB'(2));
    repeat (8) tick();
    bus.ack_user2bridge[1] = 1'b0;

    // Three words on every port, then reset discards them.
    for (int unsigned k = 0; k < 3; k++) begin
      for (int p = 0; p < NI; p++) begin
        bus.vld_interface2user[p] = 1'b1;
        bus.dout_leaf_interface2user[p*PB +: PB] = {8'(p), 24'($urandom)};
      end
      for (int p = 0; p < NO; p++) begin
        bus.vld_user2bridge[p] = 1'b1;
        bus.din_user2bridge[p*PB +: PB] = {8'(p + 8'h80), 24'($urandom)};
      end
      tick();
    end
    bus.vld_interface2user = '0;
    bus.vld_user2bridge    = '0;
    chk("pre_reset_busy", PB'({in_busy, out_busy}), PB'(2'b11));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_reset_vld_in",  PB'(bus.vld_bridge2user),    '0);
    chk("post_reset_vld_out", PB'(bus.vld_user2interface), '0);
    chk("post_reset_busy",    PB'({in_busy, out_busy}),   '0);

    // Random traffic on all ports; sources hold data until accepted.
    for (int unsigned c = 0; c < 3000; c++) begin
      for (int p = 0; p < NI; p++) begin
        if (!bus.vld_interface2user[p] || in_fire[p]) begin
          bus.vld_interface2user[p] = ($urandom_range(0, 99) < 60);
          bus.dout_leaf_interface2user[p*PB +: PB] = {8'(p), 24'($urandom)};
        end
        bus.ack_user2bridge[p] = ($urandom_range(0, 99) < 55);
      end
      for (int p = 0; p < NO; p++) begin
        if (!bus.vld_user2bridge[p] || out_fire[p]) begin
          bus.vld_user2bridge[p] = ($urandom_range(0, 99) < 60);
          bus.din_user2bridge[p*PB +: PB] = {8'(p + 8'h80), 24'($urandom)};
        end
        bus.ack_interface2user[p] = ($urandom_range(0, 99) < 55);
      end
      if ($urandom_range(0, 19) == 0) resend = ~resend;
      tick();
    end

    bus.vld_interface2user = '0;
    bus.vld_user2bridge    = '0;
    bus.ack_user2bridge    = '1;
    bus.ack_interface2user = '1;
    resend = 1'b0;
    repeat (20) tick();
    chk("drained_busy", PB'({in_busy, out_busy}), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
